load_agu: RTL and testbench
===========================

Name: load_agu

Overview:
- Load address-generation unit. It sits between the load reservation-station issue port and the load queue's address-update port.
- Adds the base register value to the sign-extended immediate and checks alignment.
- Delivers the result, tagged with the load-queue index and ROB index, to the load queue.
- Two-stage valid/ready pipeline: operand register, then result register. The result is held under load-queue write-port backpressure. Flush is supported.

Parameters:
- ADDR_W, `ADDR_LEN, address width.
- DATA_W, `DATA_LEN, base register value width (must be >= ADDR_W; low ADDR_W bits used).
- IMM_W, `IMM_LEN, immediate width (must be <= ADDR_W).
- LQ_W, `LQ_SEL, load-queue index width.
- ROB_W, `ROB_SEL, ROB index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  pipeline kill (mispredict/exception); synchronous.
- issue_valid  in  1  load operation offered by issue logic.
- issue_ready  out  1  AGU accepts the operation this cycle (combinational).
- issue_base  in  DATA_W  base register value.
- issue_imm  in  IMM_W  immediate offset, two's complement.
- issue_size  in  2  access size: 0 byte, 1 half, 2 word, 3 reserved.
- issue_lq_idx  in  LQ_W  load-queue entry to update.
- issue_rob_idx  in  ROB_W  ROB index of the load.
- lq_wr_ready  in  1  load-queue address-update port free this cycle.
- address_ready  out  1  result valid toward the load queue (registered).
- calculated_address  out  ADDR_W  effective address (registered).
- update_lq_idx  out  LQ_W  load-queue entry for the result (registered).
- update_rob_idx  out  ROB_W  ROB index for the result (registered).
- misaligned  out  1  alignment fault flag travelling with the result (registered).
- agu_busy  out  1  a_valid | b_valid.

Behaviour:
- State:
  - Stage A: a_valid, base, imm, size, lq_idx, rob_idx.
  - Stage B: b_valid (drives address_ready), address, lq_idx, rob_idx, misaligned.
- Handshake:
  - b_fire = b_valid & lq_wr_ready.
  - b_free = !b_valid | b_fire.
  - a_fire = a_valid & b_free.
  - issue_ready = !flush & (!a_valid | a_fire).
  - An operation is accepted when issue_valid & issue_ready.
- Stage A update:
  - On accept: load operands, a_valid <= 1.
  - Else if a_fire: a_valid <= 0.
  - Else: hold.
- Stage B update:
  - On a_fire: address <= base[ADDR_W-1:0] + sext(imm), modulo 2^ADDR_W with no carry-out. Copy indices, compute misaligned, b_valid <= 1.
  - Else if b_fire: b_valid <= 0.
  - Else: hold all B fields stable (outputs must not change while address_ready=1 and lq_wr_ready=0).
- Misaligned:
  - Computed on the computed address.
  - Half: addr[0] != 0.
  - Word: addr[1:0] != 0.
  - Byte: never.
  - Size 3 is checked as word.
  - The result is still delivered with misaligned=1; the AGU does not drop it.
- Latency and throughput:
  - Accept in cycle N gives address_ready=1 in cycle N+2 when not stalled.
  - Sustained throughput is 1 op/cycle while lq_wr_ready=1.
- Backpressure:
  - With lq_wr_ready=0, B holds and A fills.
  - issue_ready falls once A and B are both full.
  - Up to 2 ops are in flight. No op is lost or duplicated.
- Flush:
  - Next cycle a_valid=0 and b_valid=0.
  - Any issue offered in the flush cycle is not accepted (issue_ready=0).
  - A B result is counted as delivered (b_fire) in the flush cycle only if lq_wr_ready=1 in that cycle; otherwise it is discarded.
- Reset:
  - Overrides flush and all handshakes.
  - In the next cycle: a_valid=0, b_valid=0, address_ready=0, calculated_address=0, update_lq_idx=0, update_rob_idx=0, misaligned=0, agu_busy=0.
  - issue_ready is 1 after reset (flush low).
  - Reset asserted mid-stall discards both in-flight ops.
- Simultaneous events:
  - Accept and a_fire in the same cycle replaces A's contents (pass-through).
  - a_fire and b_fire in the same cycle replaces B's contents.

Test Plan:
- Basic:
  - Stimulus: reset, then issue base=0x0000_1000, imm=0x010, size=2, lq_idx=3, rob_idx=5, lq_wr_ready=1.
  - Response: 2 cycles later address_ready=1 for one cycle, calculated_address=0x0000_1010, update_lq_idx=3, update_rob_idx=5, misaligned=0.
- Negative immediate and wrap:
  - Stimulus 1: base=0x0000_0004, imm=-8 (sign-extended).
  - Response: address 0xFFFF_FFFC.
  - Stimulus 2: base=0xFFFF_FFF0, imm=0x20.
  - Response: address 0x0000_0010 (wrap, no carry).
- Alignment:
  - size=1, address 0x1001 -> misaligned=1.
  - size=2, address 0x1002 -> misaligned=1.
  - size=0, address 0x1003 -> misaligned=0.
  - size=3, address 0x1004 -> misaligned=0.
- Backpressure:
  - Stimulus: hold lq_wr_ready=0 and issue 3 back-to-back ops.
  - Response: ops 1 and 2 are accepted; issue_ready=0 for op 3; B outputs stay stable.
  - Stimulus: raise lq_wr_ready.
  - Response: ops drain in order 1, 2, 3 on consecutive cycles.
- Flush:
  - Stimulus: with A and B both full and lq_wr_ready=0, assert flush for 1 cycle while issue_valid=1.
  - Response: next cycle address_ready=0, agu_busy=0; the flush-cycle op is not accepted; a new issue afterwards completes normally.
- Reset mid-operation:
  - Stimulus: assert reset with 2 ops in flight, together with flush=1.
  - Response: all outputs are 0 the next cycle; no stale result ever appears on address_ready.

Source files
------------

// File: rtl/load_agu.sv
// load_agu -- load address-generation unit.
//
// Sits between the load reservation-station issue port and the load queue's
// address-update port. Each accepted load has its effective address computed
// as base + sign-extended immediate (modulo 2^ADDR_W). The address is checked
// for natural alignment and delivered together with its load-queue and ROB
// indices.
//
// Pipeline: stage A (operand register) -> stage B (result register), both
// valid/ready. Stage B holds its result stable under load-queue backpressure.
// At most two operations are in flight.
//
// Ports:
//   clk                 clock, all state updates on rising edge
//   reset               synchronous active-high reset, overrides everything
//   flush               synchronous pipeline kill, empties both stages
//   issue_valid         load offered by issue logic
//   issue_ready         AGU accepts the offered load this cycle (combinational)
//   issue_base          base register value (low ADDR_W bits used)
//   issue_imm           two's-complement immediate offset
//   issue_size          access size: 0 byte, 1 half, 2 word, 3 reserved (as word)
//   issue_lq_idx        load-queue entry to update
//   issue_rob_idx       ROB index of the load
//   lq_wr_ready         load-queue address-update port free this cycle
//   address_ready       result valid toward the load queue (registered)
//   calculated_address  effective address (registered)
//   update_lq_idx       load-queue entry for the result (registered)
//   update_rob_idx      ROB index for the result (registered)
//   misaligned          alignment fault flag travelling with the result
//   agu_busy            either pipeline stage holds an operation

module load_agu #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMM_W  = 12,
  parameter int unsigned LQ_W   = 4,
  parameter int unsigned ROB_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,

  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [DATA_W-1:0] issue_base,
  input  logic [IMM_W-1:0]  issue_imm,
  input  logic [1:0]        issue_size,
  input  logic [LQ_W-1:0]   issue_lq_idx,
  input  logic [ROB_W-1:0]  issue_rob_idx,

  input  logic              lq_wr_ready,
  output logic              address_ready,
  output logic [ADDR_W-1:0] calculated_address,
  output logic [LQ_W-1:0]   update_lq_idx,
  output logic [ROB_W-1:0]  update_rob_idx,
  output logic              misaligned,

  output logic              agu_busy
);

  // ---------------------------------------------------------------------------
  // Stage A: operand register
  // ---------------------------------------------------------------------------
  logic              r_a_valid;
  logic [ADDR_W-1:0] r_a_base;
  logic [IMM_W-1:0]  r_a_imm;
  logic [1:0]        r_a_size;
  logic [LQ_W-1:0]   r_a_lq_idx;
  logic [ROB_W-1:0]  r_a_rob_idx;

  // ---------------------------------------------------------------------------
  // Stage B: result register
  // ---------------------------------------------------------------------------
  logic              r_b_valid;
  logic [ADDR_W-1:0] r_b_addr;
  logic [LQ_W-1:0]   r_b_lq_idx;
  logic [ROB_W-1:0]  r_b_rob_idx;
  logic              r_b_misaligned;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic w_b_fire;
  logic w_b_free;
  logic w_a_fire;
  logic w_accept;

  always_comb begin
    w_b_fire    = r_b_valid & lq_wr_ready;
    w_b_free    = ~r_b_valid | w_b_fire;
    w_a_fire    = r_a_valid & w_b_free;
    issue_ready = ~flush & (~r_a_valid | w_a_fire);
    w_accept    = issue_valid & issue_ready;
  end

  // ---------------------------------------------------------------------------
  // Address computation and alignment check (combinational on stage A)
  // ---------------------------------------------------------------------------
  logic signed [IMM_W-1:0]  w_imm_s;
  logic signed [ADDR_W-1:0] w_imm_ext;
  logic        [ADDR_W-1:0] w_addr;
  logic                     w_misaligned;

  always_comb begin
    // Signed-to-wider-signed assignment performs the sign extension; it also
    // stays legal when IMM_W == ADDR_W, where a replication count would be 0.
    w_imm_s   = r_a_imm;
    w_imm_ext = w_imm_s;
    // Carry-out is dropped: the sum wraps modulo 2^ADDR_W.
    w_addr    = r_a_base + w_imm_ext;
  end

  always_comb begin
    w_misaligned = 1'b0;
    unique case (r_a_size)
      2'd0:    w_misaligned = 1'b0;
      2'd1:    w_misaligned = w_addr[0];
      default: w_misaligned = (w_addr[1:0] != 2'b00);  // word and reserved
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage A update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_valid   <= 1'b0;
      r_a_base    <= '0;
      r_a_imm     <= '0;
      r_a_size    <= '0;
      r_a_lq_idx  <= '0;
      r_a_rob_idx <= '0;
    end else if (flush) begin
      r_a_valid   <= 1'b0;
    end else if (w_accept) begin
      // Also covers accept together with a_fire: A's contents are replaced.
      r_a_valid   <= 1'b1;
      r_a_base    <= issue_base[ADDR_W-1:0];
      r_a_imm     <= issue_imm;
      r_a_size    <= issue_size;
      r_a_lq_idx  <= issue_lq_idx;
      r_a_rob_idx <= issue_rob_idx;
    end else if (w_a_fire) begin
      r_a_valid   <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage B update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_b_valid      <= 1'b0;
      r_b_addr       <= '0;
      r_b_lq_idx     <= '0;
      r_b_rob_idx    <= '0;
      r_b_misaligned <= 1'b0;
    end else if (flush) begin
      r_b_valid      <= 1'b0;
    end else if (w_a_fire) begin
      // Also covers a_fire together with b_fire: B's contents are replaced.
      r_b_valid      <= 1'b1;
      r_b_addr       <= w_addr;
      r_b_lq_idx     <= r_a_lq_idx;
      r_b_rob_idx    <= r_a_rob_idx;
      r_b_misaligned <= w_misaligned;
    end else if (w_b_fire) begin
      r_b_valid      <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    address_ready      = r_b_valid;
    calculated_address = r_b_addr;
    update_lq_idx      = r_b_lq_idx;
    update_rob_idx     = r_b_rob_idx;
    misaligned         = r_b_misaligned;
    agu_busy           = r_a_valid | r_b_valid;
  end

endmodule

// File: tb/tb_load_agu.sv
// Self-checking bench for load_agu.
// A queue-based model tracks in-flight loads in order; each entry ages by one
// per clock edge and the oldest entry is visible on the output once it has
// seen at least one edge. Directed vectors pin the model with literal values.

module tb_load_agu;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        issue_valid, issue_ready;
  logic [31:0] issue_base;
  logic [11:0] issue_imm;
  logic [1:0]  issue_size;
  logic [3:0]  issue_lq_idx;
  logic [5:0]  issue_rob_idx;
  logic        lq_wr_ready, address_ready, misaligned, agu_busy;
  logic [31:0] calculated_address;
  logic [3:0]  update_lq_idx;
  logic [5:0]  update_rob_idx;

  always #5 clk = ~clk;

  load_agu #(
    .ADDR_W(32), .DATA_W(32), .IMM_W(12), .LQ_W(4), .ROB_W(6)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_base(issue_base), .issue_imm(issue_imm), .issue_size(issue_size),
    .issue_lq_idx(issue_lq_idx), .issue_rob_idx(issue_rob_idx),
    .lq_wr_ready(lq_wr_ready), .address_ready(address_ready),
    .calculated_address(calculated_address), .update_lq_idx(update_lq_idx),
    .update_rob_idx(update_rob_idx), .misaligned(misaligned),
    .agu_busy(agu_busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  lq;
    logic [5:0]  rob;
    logic        mis;
    int unsigned age;
  } op_t;

  op_t q[$];
  bit  check_en   = 1'b0;
  bit  m_last_acc = 1'b0;
  int  n_checks   = 0;
  int  n_errors   = 0;

  function automatic logic [31:0] ref_addr(input logic [31:0] b, input logic [11:0] i);
    return b + {{20{i[11]}}, i};
  endfunction

  function automatic logic ref_mis(input logic [31:0] a, input logic [1:0] s);
    case (s)
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      default: return a[1:0] != 2'b00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge, from inputs and the model's own state.
  always @(posedge clk) begin : model_blk
    bit  vis, rdy, acc;
    op_t o;
    if (reset) begin
      q.delete();
      check_en   = 1'b1;
      m_last_acc = 1'b0;
    end else begin
      vis = (q.size() > 0) && (q[0].age >= 1);
      rdy = !flush && ((q.size() < 2) || lq_wr_ready);
      acc = issue_valid && rdy;
      m_last_acc = acc;
      if (vis && lq_wr_ready) void'(q.pop_front());
      if (flush) q.delete();
      else begin
        foreach (q[i]) q[i].age++;
        if (acc) begin
          o.addr = ref_addr(issue_base, issue_imm);
          o.mis  = ref_mis(o.addr, issue_size);
          o.lq   = issue_lq_idx;
          o.rob  = issue_rob_idx;
          o.age  = 0;
          q.push_back(o);
        end
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin : cmp_blk
    bit exp_ar;
    if (check_en) begin
      exp_ar = (q.size() > 0) && (q[0].age >= 1);
      chk("m_address_ready", address_ready, exp_ar);
      chk("m_agu_busy", agu_busy, q.size() > 0);
      chk("m_issue_ready", issue_ready, !flush && ((q.size() < 2) || lq_wr_ready));
      if (exp_ar && address_ready) begin
        chk("m_address", calculated_address, q[0].addr);
        chk("m_lq_idx", update_lq_idx, q[0].lq);
        chk("m_rob_idx", update_rob_idx, q[0].rob);
        chk("m_misaligned", misaligned, q[0].mis);
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [31:0] b, input logic [11:0] imm, input logic [1:0] sz,
                       input logic [3:0] lq, input logic [5:0] rob);
    int n = 0;
    issue_valid = 1'b1; issue_base = b; issue_imm = imm; issue_size = sz;
    issue_lq_idx = lq; issue_rob_idx = rob;
    do begin @(posedge clk); #1; n++; end while (!m_last_acc && n < 20);
    issue_valid = 1'b0;
    if (!m_last_acc) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_lit(input string name, input logic [31:0] a, input logic [3:0] lq,
                            input logic [5:0] rob, input logic mis);
    int n = 0;
    do begin @(negedge clk); n++; end while (!address_ready && n < 8);
    chk({name, "_valid"}, address_ready, 32'd1);
    chk({name, "_latency"}, n, 32'd2);
    chk({name, "_addr"}, calculated_address, a);
    chk({name, "_lq"}, update_lq_idx, lq);
    chk({name, "_rob"}, update_rob_idx, rob);
    chk({name, "_mis"}, misaligned, mis);
    @(negedge clk);
    chk({name, "_pulse"}, address_ready, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string name);
    chk({name, "_ar"}, address_ready, 32'd0);
    chk({name, "_addr"}, calculated_address, 32'd0);
    chk({name, "_lq"}, update_lq_idx, 32'd0);
    chk({name, "_rob"}, update_rob_idx, 32'd0);
    chk({name, "_mis"}, misaligned, 32'd0);
    chk({name, "_busy"}, agu_busy, 32'd0);
    chk({name, "_iready"}, issue_ready, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_base = '0; issue_imm = '0;
    issue_size = '0; issue_lq_idx = '0; issue_rob_idx = '0; lq_wr_ready = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 reset = 1'b0;

    // Basic, negative immediate, wrap
    issue(32'h0000_1000, 12'h010, 2'd2, 4'd3, 6'd5);
    expect_lit("basic", 32'h0000_1010, 4'd3, 6'd5, 1'b0);
    issue(32'h0000_0004, 12'hFF8, 2'd2, 4'd1, 6'd2);
    expect_lit("neg_imm", 32'hFFFF_FFFC, 4'd1, 6'd2, 1'b0);
    issue(32'hFFFF_FFF0, 12'h020, 2'd0, 4'd2, 6'd7);
    expect_lit("wrap", 32'h0000_0010, 4'd2, 6'd7, 1'b0);

    // Alignment
    issue(32'h0000_1000, 12'h001, 2'd1, 4'd4, 6'd8);
    expect_lit("half_mis", 32'h0000_1001, 4'd4, 6'd8, 1'b1);
    issue(32'h0000_1000, 12'h002, 2'd2, 4'd5, 6'd9);
    expect_lit("word_mis", 32'h0000_1002, 4'd5, 6'd9, 1'b1);
    issue(32'h0000_1000, 12'h003, 2'd0, 4'd6, 6'd10);
    expect_lit("byte_ok", 32'h0000_1003, 4'd6, 6'd10, 1'b0);
    issue(32'h0000_1000, 12'h004, 2'd3, 4'd7, 6'd11);
    expect_lit("rsvd_ok", 32'h0000_1004, 4'd7, 6'd11, 1'b0);
    issue(32'h0000_1000, 12'h006, 2'd3, 4'd8, 6'd12);
    expect_lit("rsvd_mis", 32'h0000_1006, 4'd8, 6'd12, 1'b1);

    // Back-to-back throughput, checked by the model
    for (int i = 0; i < 5; i++)
      issue(32'h0000_4000 + 32'(i * 3), 12'h7FF, 2'(i), 4'(i), 6'(i + 20));
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: two accepted, third refused, then ordered drain
    lq_wr_ready = 1'b0;
    issue(32'h0000_2000, 12'h004, 2'd2, 4'd1, 6'd1);
    issue(32'h0000_2000, 12'h008, 2'd2, 4'd2, 6'd2);
    issue_valid = 1'b1; issue_base = 32'h0000_2000; issue_imm = 12'h00C;
    issue_size = 2'd2; issue_lq_idx = 4'd3; issue_rob_idx = 6'd3;
    repeat (3) @(negedge clk);
    chk("bp_iready_low", issue_ready, 32'd0);
    chk("bp_hold_ar", address_ready, 32'd1);
    chk("bp_hold_addr", calculated_address, 32'h0000_2004);
    chk("bp_hold_lq", update_lq_idx, 32'd1);
    @(posedge clk); #1 lq_wr_ready = 1'b1;
    @(negedge clk);
    chk("bp_iready_rise", issue_ready, 32'd1);
    chk("bp_d1_addr", calculated_address, 32'h0000_2004);
    @(posedge clk); #1 issue_valid = 1'b0;
    @(negedge clk);
    chk("bp_d2_addr", calculated_address, 32'h0000_2008);
    chk("bp_d2_lq", update_lq_idx, 32'd2);
    @(negedge clk);
    chk("bp_d3_addr", calculated_address, 32'h0000_200C);
    chk("bp_d3_lq", update_lq_idx, 32'd3);
    @(negedge clk);
    chk("bp_drained", address_ready, 32'd0);

    // Flush with both stages full and an offered op
    @(posedge clk); #1 lq_wr_ready = 1'b0;
    issue(32'h0000_5000, 12'h000, 2'd2, 4'd9, 6'd30);
    issue(32'h0000_5000, 12'h004, 2'd2, 4'd10, 6'd31);
    issue_valid = 1'b1; issue_base = 32'h0000_5000; issue_imm = 12'h008; flush = 1'b1;
    @(negedge clk);
    chk("flush_iready", issue_ready, 32'd0);
    chk("flush_busy_before", agu_busy, 32'd1);
    @(posedge clk); #1 flush = 1'b0; issue_valid = 1'b0;
    @(negedge clk);
    chk("flush_ar", address_ready, 32'd0);
    chk("flush_busy", agu_busy, 32'd0);
    @(posedge clk); #1 lq_wr_ready = 1'b1;
    issue(32'h0000_3000, 12'h040, 2'd1, 4'd7, 6'd9);
    expect_lit("post_flush", 32'h0000_3040, 4'd7, 6'd9, 1'b0);

    // Reset with two ops in flight, together with flush
    lq_wr_ready = 1'b0;
    issue(32'h0000_6000, 12'h001, 2'd1, 4'd11, 6'd40);
    issue(32'h0000_6000, 12'h002, 2'd2, 4'd12, 6'd41);
    reset = 1'b1; flush = 1'b1; issue_valid = 1'b1;
    @(posedge clk); #1 reset = 1'b0; flush = 1'b0; issue_valid = 1'b0; lq_wr_ready = 1'b1;
    @(negedge clk);
    check_zero("mid_reset");
    repeat (4) begin
      @(negedge clk);
      chk("no_stale", address_ready, 32'd0);
    end
    @(posedge clk); #1;
    issue(32'h0000_7000, 12'hFFE, 2'd1, 4'd15, 6'd63);
    expect_lit("post_reset", 32'h0000_6FFE, 4'd15, 6'd63, 1'b0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
